// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the kFPGA configuration loader: FSM states, CRC constants,
// shift-counter width and the serial CRC step.
package kfpga_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_READBACK,
        ST_FINISH
    } state_e;

    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam int          SHIFT_CNT_W = 16;

    // One step of CRC-16-CCITT, MSB-first feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/kfpga_crc16_serial.sv
// kfpga_crc16_serial: bit-serial CRC-16-CCITT accumulator, one bit per enabled cycle,
// with a synchronous clear back to the init value.
module kfpga_crc16_serial
    import kfpga_config_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else if (clear_i) begin
            crc_q <= CRC_INIT;
        end else if (enable_i) begin
            crc_q <= crc16_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: clears the core configuration chain, then streams host words into it LSB-first.
// Build option: define KFPGA_CONFIG_READBACK_EN to add a CRC-checked recirculating readback pass.
module kfpga_config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_WIDTH   = 32,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] word_data_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    output logic                  config_data_o,
    output logic                  config_enable_o,
    output logic                  config_nreset_o,
    input  logic                  config_return_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int                     HOLD_W     = $clog2(WORD_WIDTH + 1);
    localparam logic [SHIFT_CNT_W-1:0] LAST_SHIFT = SHIFT_CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [7:0]             LAST_CLEAR = 8'(CLEAR_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      FULL_WORD  = HOLD_W'(WORD_WIDTH);

    state_e                 state_q;
    logic [7:0]             clear_cnt_q;
    logic [SHIFT_CNT_W-1:0] shift_cnt_q;
    logic [WORD_WIDTH-1:0]  hold_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic                   done_q;

    logic start_accept;
    logic load_shift;
    logic word_accept;

    assign start_accept    = (state_q == ST_IDLE) && start_i;
    assign load_shift      = (state_q == ST_LOAD) && (hold_cnt_q != '0);
    assign word_ready_o    = (state_q == ST_LOAD) && (hold_cnt_q == '0);
    assign word_accept     = word_ready_o && word_valid_i;
    assign config_nreset_o = (state_q != ST_CLEAR);
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            clear_cnt_q <= '0;
            shift_cnt_q <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_CLEAR;
                        clear_cnt_q <= '0;
                        shift_cnt_q <= '0;
                        hold_cnt_q  <= '0;
                    end
                end
                ST_CLEAR: begin
                    clear_cnt_q <= clear_cnt_q + 8'd1;
                    if (clear_cnt_q == LAST_CLEAR) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (word_accept) begin
                        hold_q     <= word_data_i;
                        hold_cnt_q <= FULL_WORD;
                    end else if (load_shift) begin
                        hold_q      <= hold_q >> 1;
                        hold_cnt_q  <= hold_cnt_q - 1'b1;
                        shift_cnt_q <= shift_cnt_q + 1'b1;
                        // Last chain bit: drop whatever is left of the final word.
                        if (shift_cnt_q == LAST_SHIFT) begin
                            hold_cnt_q <= '0;
`ifdef KFPGA_CONFIG_READBACK_EN
                            state_q     <= ST_READBACK;
                            shift_cnt_q <= '0;
`else
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KFPGA_CONFIG_READBACK_EN
                ST_READBACK: begin
                    // The shift counter is reused to time one full recirculation.
                    shift_cnt_q <= shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_SHIFT) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
`endif
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KFPGA_CONFIG_READBACK_EN
    logic        rb_active;
    logic [15:0] crc_load;
    logic [15:0] crc_back;
    logic        error_q;

    assign rb_active = (state_q == ST_READBACK);

    kfpga_crc16_serial u_crc_load (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (start_accept),
        .enable_i (load_shift),
        .bit_i    (hold_q[0]),
        .crc_o    (crc_load)
    );

    kfpga_crc16_serial u_crc_back (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (start_accept),
        .enable_i (rb_active),
        .bit_i    (config_return_i),
        .crc_o    (crc_back)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (start_accept) begin
            error_q <= 1'b0;
        end else if ((state_q == ST_FINISH) && (crc_load != crc_back)) begin
            error_q <= 1'b1;
        end
    end

    assign error_o         = error_q;
    assign config_enable_o = load_shift | rb_active;
    assign config_data_o   = load_shift ? hold_q[0] : (rb_active & config_return_i);
`else
    logic unused_return;
    assign unused_return   = config_return_i;
    assign error_o         = 1'b0;
    assign config_enable_o = load_shift;
    assign config_data_o   = load_shift & hold_q[0];
`endif

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Bench for kfpga_config_loader: two instances (64-bit and 40-bit chains) driven by a behavioural
// core-chain model; expectations come from word concatenation and cycle-budget arithmetic.
module tb_kfpga_config_loader;

`ifdef KFPGA_CONFIG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk;
    logic        rst;
    logic        start   [2];
    logic [31:0] wdata   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic        cdata   [2];
    logic        cen     [2];
    logic        cnres   [2];
    logic        cret    [2];
    logic        busy    [2];
    logic        done    [2];
    logic        err     [2];

    // Stimulus controls, owned by the initial block.
    logic        vbase    [2];
    logic        mon_clr  [2];
    logic        flip_now [2];
    int          gap_len  [2];
    logic [31:0] words    [2][4];

    // Chain model and bookkeeping, owned by the monitor.
    logic [63:0] chain    [2];
    logic [63:0] stream   [2];
    int          en_cnt   [2];
    int          acc_cnt  [2];
    int          busy_cyc [2];
    int          idle_load[2];
    int          nres_low [2];
    int          done_cnt [2];
    int          gap_cnt  [2];
    int          widx     [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int chain_len(input int d);
        return (d == 0) ? 64 : 40;
    endfunction

    function automatic int clear_len(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    kfpga_config_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(32), .CLEAR_CYCLES(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .word_data_i(wdata[0]),
        .word_valid_i(wvalid[0]), .word_ready_o(wready[0]), .config_data_o(cdata[0]),
        .config_enable_o(cen[0]), .config_nreset_o(cnres[0]), .config_return_i(cret[0]),
        .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0])
    );

    kfpga_config_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(32), .CLEAR_CYCLES(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .word_data_i(wdata[1]),
        .word_valid_i(wvalid[1]), .word_ready_o(wready[1]), .config_data_o(cdata[1]),
        .config_enable_o(cen[1]), .config_nreset_o(cnres[1]), .config_return_i(cret[1]),
        .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            wdata[d]  = words[d][widx[d] % 4];
            wvalid[d] = vbase[d] && (gap_cnt[d] == 0);
            cret[d]   = chain[d][chain_len(d) - 1];
        end
    end

    // Core chain plus per-load bookkeeping, all advanced on the configuration clock edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cen[d]) begin
                chain[d] <= {chain[d][62:0], cdata[d]} ^ (flip_now[d] ? 64'd32 : 64'd0);
            end else if (flip_now[d]) begin
                chain[d] <= chain[d] ^ 64'd32;
            end
            if (mon_clr[d]) begin
                stream[d]    <= '0;
                en_cnt[d]    <= 0;
                acc_cnt[d]   <= 0;
                busy_cyc[d]  <= 0;
                idle_load[d] <= 0;
                nres_low[d]  <= 0;
                done_cnt[d]  <= 0;
                widx[d]      <= 0;
                gap_cnt[d]   <= gap_len[d];
            end else begin
                if (cen[d]) begin
                    if (en_cnt[d] < 64) stream[d][en_cnt[d]] <= cdata[d];
                    en_cnt[d] <= en_cnt[d] + 1;
                end
                if (wvalid[d] && wready[d]) begin
                    acc_cnt[d] <= acc_cnt[d] + 1;
                    widx[d]    <= widx[d] + 1;
                    gap_cnt[d] <= gap_len[d];
                end else if (wready[d] && gap_cnt[d] > 0) begin
                    gap_cnt[d] <= gap_cnt[d] - 1;
                end
                if (busy[d]) busy_cyc[d] <= busy_cyc[d] + 1;
                if (busy[d] && cnres[d] && !cen[d] && !done[d]) idle_load[d] <= idle_load[d] + 1;
                if (!cnres[d]) nres_low[d] <= nres_low[d] + 1;
                if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_load(input int d, input int gap, input bit poke, input bit flip,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int exp_acc, input bit exp_err_rb);
        int          len;
        int          nw;
        int          cyc;
        bit          poked;
        bit          flipped;
        logic [63:0] exp_stream;
        logic [63:0] exp_chain;
        logic [63:0] mask;
        len = chain_len(d);
        nw  = (len + 31) / 32;
        words[d][0] = w0;
        words[d][1] = w1;
        words[d][2] = $urandom;
        words[d][3] = $urandom;
        gap_len[d]  = gap;
        @(negedge clk);
        mon_clr[d] = 1'b1;
        vbase[d]   = 1'b1;
        @(negedge clk);
        mon_clr[d] = 1'b0;
        start[d]   = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check("start_busy", busy[d], 1);
        check("start_clear_low", cnres[d], 0);
        check("start_error_cleared", err[d], 0);
        poked = 0;
        flipped = 0;
        cyc = 0;
        while (!(done_cnt[d] > 0 && !busy[d]) && cyc < 3000) begin
            start[d] = poke && !poked && (en_cnt[d] == 10);
            if (start[d]) poked = 1;
            flip_now[d] = flip && !flipped && (en_cnt[d] == 20);
            if (flip_now[d]) flipped = 1;
            @(negedge clk);
            cyc++;
        end
        start[d]    = 1'b0;
        flip_now[d] = 1'b0;
        check("load_timeout", cyc < 3000, 1);
        repeat (3) @(negedge clk);

        exp_stream = '0;
        exp_chain  = '0;
        for (int i = 0; i < len; i++) exp_stream[i] = (i < 32) ? w0[i] : w1[i - 32];
        for (int i = 0; i < len; i++) exp_chain[i] = exp_stream[len - 1 - i];
        mask = (len == 64) ? {64{1'b1}} : ((64'd1 << len) - 64'd1);

        check("enable_pulses", en_cnt[d], len * (1 + RB));
        check("bit_stream", stream[d], exp_stream);
        check("words_accepted", acc_cnt[d], exp_acc);
        check("nreset_low_cycles", nres_low[d], clear_len(d));
        check("done_pulses", done_cnt[d], 1);
        check("load_idle_cycles", idle_load[d], nw * (gap + 1));
        check("busy_cycles", busy_cyc[d], clear_len(d) + nw * (gap + 1) + len * (1 + RB) + 1);
        check("error_flag", err[d], exp_err_rb && (RB == 1));
        check("ready_after_load", wready[d], 0);
        check("idle_after_load", busy[d], 0);
        if (!flip) check("chain_content", chain[d] & mask, exp_chain);
    endtask

    typedef struct {
        int          d;
        int          gap;
        bit          poke;
        bit          flip;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_acc;
        bit          exp_err_rb;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cyc;
        tbl[0] = '{0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678, 2, 1'b0};
        tbl[1] = '{1, 0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hA5A5A55A, 2, 1'b0};
        tbl[2] = '{0, 5, 1'b0, 1'b0, 32'h0F0F1234, 32'h80000001, 2, 1'b0};
        tbl[3] = '{0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 2, 1'b1};
        tbl[4] = '{0, 0, 1'b0, 1'b0, 32'h13579BDF, 32'h2468ACE0, 2, 1'b0};
        tbl[5] = '{0, 2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0};
        tbl[6] = '{1, 3, 1'b1, 1'b1, 32'h76543210, 32'h000000C3, 2, 1'b1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]    = 1'b0;
            vbase[d]    = 1'b0;
            mon_clr[d]  = 1'b1;
            flip_now[d] = 1'b0;
            gap_len[d]  = 0;
            for (int k = 0; k < 4; k++) words[d][k] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", busy[d], 0);
            check("reset_enable", cen[d], 0);
            check("reset_nreset", cnres[d], 1);
            check("reset_ready", wready[d], 0);
            check("reset_done", done[d], 0);
            check("reset_error", err[d], 0);
            check("reset_data", cdata[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        mon_clr[0] = 1'b0;
        mon_clr[1] = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_load(tbl[i].d, tbl[i].gap, tbl[i].poke, tbl[i].flip,
                     tbl[i].w0, tbl[i].w1, tbl[i].exp_acc, tbl[i].exp_err_rb);
        end

        for (int i = 0; i < 6; i++) begin
            run_load(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, 2, 1'b0);
        end

        // Reset in the middle of a load, then a clean reload.
        words[0][0] = 32'h55AA33CC;
        words[0][1] = 32'h0123ABCD;
        gap_len[0]  = 0;
        @(negedge clk);
        mon_clr[0] = 1'b1;
        vbase[0]   = 1'b1;
        @(negedge clk);
        mon_clr[0] = 1'b0;
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (en_cnt[0] < 20 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_wait_timeout", cyc < 500, 1);
        check("mid_load_busy", busy[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", busy[0], 0);
        check("async_enable", cen[0], 0);
        check("async_nreset", cnres[0], 1);
        check("async_ready", wready[0], 0);
        check("async_done", done[0], 0);
        check("async_error", err[0], 0);
        check("async_data", cdata[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_load(0, 1, 1'b0, 1'b0, 32'h89ABCDEF, 32'hFEDCBA98, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
